// File: rtl/sub.sv
// sub: ramp counter with IDLE/RUN/PAUSE sequencing plus free-running
// toggles, a periodic strobe and a 16-bit Galois LFSR.
// Optional feature: define SUB_GRAY_EN to get a registered Gray-coded copy
// of cnt on the gray output; otherwise gray is tied to zero.
module sub #(
   parameter int          CNT_W        = 8,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          PULSE_PERIOD = 16,
   parameter int          PAUSE_LEN    = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] cnt,
   output logic [1:0]       state,
   output logic             tgl,
   output logic             tgl4,
   output logic             pulse,
   output logic [15:0]      lfsr,
   output logic             parity,
   output logic [CNT_W-1:0] gray
);

   localparam int PW  = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;
   localparam int PCW = $clog2(PULSE_PERIOD);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   // Every register carries its reset value as a power-up value so the block
   // behaves the same whether or not reset is ever asserted.
   state_t           state_q  = IDLE;
   logic [CNT_W-1:0] cnt_q    = '0;
   logic [CNT_W-1:0] cnt_next;
   logic [PW-1:0]    pause_q  = '0;
   logic             tgl_q    = 1'b0;
   logic             tgl4_q   = 1'b0;
   logic [1:0]       div_q    = 2'd0;
   logic             pulse_q  = 1'b0;
   logic [PCW-1:0]   period_q = '0;
   logic [15:0]      lfsr_q   = LFSR_SEED;

   // Counter only advances in RUN; the all-ones wrap and every other state give zero.
   always_comb begin
      cnt_next = '0;
      if (state_q == RUN && cnt_q != '1) begin
         cnt_next = cnt_q + 1'b1;
      end
   end

   // Sequencer: IDLE -> RUN, RUN -> PAUSE on counter wrap, PAUSE -> RUN after PAUSE_LEN cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pause_q <= '0;
      end else begin
         cnt_q <= cnt_next;
         case (state_q)
            IDLE: begin
               state_q <= RUN;
            end
            RUN: begin
               if (cnt_q == '1) begin
                  state_q <= PAUSE;
                  pause_q <= '0;
               end
            end
            PAUSE: begin
               if (pause_q == PW'(PAUSE_LEN - 1)) begin
                  state_q <= RUN;
               end else begin
                  pause_q <= pause_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Free-running toggles: tgl every cycle, tgl4 whenever the 2-bit divider wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         tgl_q  <= 1'b0;
         tgl4_q <= 1'b0;
         div_q  <= 2'd0;
      end else begin
         tgl_q <= ~tgl_q;
         div_q <= div_q + 2'd1;
         if (div_q == 2'd3) begin
            tgl4_q <= ~tgl4_q;
         end
      end
   end

   // Period counter and its one-cycle strobe, fired as the counter wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         pulse_q <= (period_q == PCW'(PULSE_PERIOD - 1));
         if (period_q == PCW'(PULSE_PERIOD - 1)) begin
            period_q <= '0;
         end else begin
            period_q <= period_q + 1'b1;
         end
      end
   end

   // Right-shifting Galois LFSR, reloading the seed if it ever locks up at zero.
   always_ff @(posedge clk) begin
      if (rst || lfsr_q == 16'h0000) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

`ifdef SUB_GRAY_EN
   logic [CNT_W-1:0] gray_q = '0;

   // Gray copy tracks the counter's next value so both update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q <= '0;
      end else begin
         gray_q <= (cnt_next >> 1) ^ cnt_next;
      end
   end

   assign gray = gray_q;
`else
   assign gray = '0;
`endif

   assign cnt    = cnt_q;
   assign state  = state_q;
   assign tgl    = tgl_q;
   assign tgl4   = tgl4_q;
   assign pulse  = pulse_q;
   assign lfsr   = lfsr_q;
   assign parity = ^lfsr_q;

endmodule

// File: tb/tb_sub.sv
// tb_sub: self-checking bench for sub. The reference model tracks only the
// number of edges since the last reset and derives every output from it with
// plain arithmetic, plus an independent LFSR stepper.
module tb_sub;

   localparam int          CNT_W        = 8;
   localparam logic [15:0] SEED         = 16'hACE1;
   localparam int          PULSE_PERIOD = 16;
   localparam int          PAUSE_LEN    = 4;
   localparam int          RAMP_LEN     = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       state;
   logic             tgl;
   logic             tgl4;
   logic             pulse;
   logic [15:0]      lfsr;
   logic             parity;
   logic [CNT_W-1:0] gray;

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset (power-up counts as reset) and LFSR value.
   int          m_n    = 0;
   logic [15:0] m_lfsr = SEED;

   sub #(
      .CNT_W(CNT_W),
      .LFSR_SEED(SEED),
      .PULSE_PERIOD(PULSE_PERIOD),
      .PAUSE_LEN(PAUSE_LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cnt(cnt),
      .state(state),
      .tgl(tgl),
      .tgl4(tgl4),
      .pulse(pulse),
      .lfsr(lfsr),
      .parity(parity),
      .gray(gray)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      if (v == 16'h0000) return SEED;
      return (v >> 1) ^ ((v & 16'h0001) != 0 ? 16'hB400 : 16'h0000);
   endfunction

   // After IDLE the sequence is a ramp of RAMP_LEN cycles then PAUSE_LEN cycles, repeating.
   task automatic check_model();
      int          k;
      int          exp_state;
      int          exp_cnt;
      int          exp_gray;
      logic [15:0] tmp;
      if (m_n == 0) begin
         exp_state = 0;
         exp_cnt   = 0;
      end else begin
         k = (m_n - 1) % (RAMP_LEN + PAUSE_LEN);
         if (k < RAMP_LEN) begin
            exp_state = 1;
            exp_cnt   = k;
         end else begin
            exp_state = 2;
            exp_cnt   = 0;
         end
      end
`ifdef SUB_GRAY_EN
      exp_gray = exp_cnt ^ (exp_cnt >> 1);
`else
      exp_gray = 0;
`endif
      tmp = m_lfsr;
      checkOutput("state", 32'(state), 32'(exp_state));
      checkOutput("cnt", 32'(cnt), 32'(exp_cnt));
      checkOutput("gray", 32'(gray), 32'(exp_gray));
      checkOutput("tgl", 32'(tgl), 32'(m_n % 2));
      checkOutput("tgl4", 32'(tgl4), 32'((m_n / 4) % 2));
      checkOutput("pulse", 32'(pulse), 32'((m_n != 0 && m_n % PULSE_PERIOD == 0) ? 1 : 0));
      checkOutput("lfsr", 32'(lfsr), 32'(m_lfsr));
      checkOutput("parity", 32'(parity), 32'(^tmp));
   endtask

   // One clock: drive rst, advance the model at the edge, compare on the falling edge.
   task automatic applyStimulus(input logic r);
      rst = r;
      @(posedge clk);
      if (r) begin
         m_n    = 0;
         m_lfsr = SEED;
      end else begin
         m_n++;
         m_lfsr = lfsr_step(m_lfsr);
      end
      @(negedge clk);
      check_model();
   endtask

   initial begin
      int pulses;
      int last_pulse;
      int hold;

      // Never reset: power-up values must carry the block.
      for (int i = 0; i < 11; i++) applyStimulus(1'b0);
      checkOutput("powerup_cnt", 32'(cnt), 32'd10);

      // Two reset cycles, then release.
      applyStimulus(1'b1);
      checkOutput("rst_lfsr", 32'(lfsr), 32'h0000ACE1);
      applyStimulus(1'b1);
      checkOutput("rst_state", 32'(state), 32'd0);
      checkOutput("rst_cnt", 32'(cnt), 32'd0);
      applyStimulus(1'b0);
      checkOutput("first_lfsr", 32'(lfsr), 32'h0000E270);
      checkOutput("first_state", 32'(state), 32'd1);

      // Pulse spacing over 64 cycles from reset.
      applyStimulus(1'b1);
      pulses     = 0;
      last_pulse = 0;
      for (int i = 1; i <= 64; i++) begin
         applyStimulus(1'b0);
         if (pulse === 1'b1) begin
            pulses++;
            checkOutput("pulse_gap", 32'(i - last_pulse), 32'(PULSE_PERIOD));
            last_pulse = i;
         end
      end
      checkOutput("pulse_count", 32'(pulses), 32'd4);

      // Ramp through the wrap into PAUSE, back to RUN, then reset mid-PAUSE.
      applyStimulus(1'b1);
      for (int i = 0; i < 257; i++) applyStimulus(1'b0);
      checkOutput("pause_entry", 32'(state), 32'd2);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0);
      checkOutput("pause_exit", 32'(state), 32'd1);
      applyStimulus(1'b0);
      checkOutput("ramp_restart", 32'(cnt), 32'd1);
      for (int i = 0; i < 257; i++) applyStimulus(1'b0);
      applyStimulus(1'b1);
      checkOutput("pause_rst_state", 32'(state), 32'd0);
      checkOutput("pause_rst_tgl", 32'(tgl), 32'd0);

      // Randomized run with occasional reset bursts of random length.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            hold = int'($urandom_range(1, 3));
            for (int j = 0; j < hold; j++) applyStimulus(1'b1);
         end else begin
            applyStimulus(1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sub.md
SUB -- requirements
Module: sub

Interface
REQ-001 Parameter CNT_W, default 8, width of the ramp counter output cnt.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset/reload value.
REQ-003 Parameter PULSE_PERIOD, default 16, cycles between pulse assertions (min 2).
REQ-004 Parameter PAUSE_LEN, default 4, cycles spent in PAUSE (min 1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cnt  output  CNT_W  ramp counter value.
REQ-008 state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE.
REQ-009 tgl  output  1  inverts every cycle.
REQ-010 tgl4  output  1  inverts every 4th cycle.
REQ-011 pulse  output  1  one-cycle strobe every PULSE_PERIOD cycles.
REQ-012 lfsr  output  16  pseudo-random sequence.
REQ-013 parity  output  1  XOR-reduction of lfsr.
REQ-014 gray  output  CNT_W  Gray code of cnt (see Configuration).

Function
REQ-015 FSM IDLE shall go to RUN on the next edge, unconditionally.
REQ-016 In RUN, cnt shall increment by 1 per edge; when cnt is all-ones, the next edge shall set cnt=0 and state=PAUSE.
REQ-017 In PAUSE, cnt shall hold 0 for exactly PAUSE_LEN cycles, then state shall return to RUN.
REQ-018 In IDLE and PAUSE, cnt shall hold at 0.
REQ-019 Illegal state encoding 3 shall transition to IDLE on the next edge, with cnt cleared.
REQ-020 tgl shall invert on every edge out of reset.
REQ-021 tgl4 shall invert whenever a free-running 2-bit divider wraps from 3 to 0.
REQ-022 pulse shall be high for exactly one cycle when a free-running period counter equals PULSE_PERIOD-1, first after PULSE_PERIOD edges out of reset; the period counter wraps to 0.
REQ-023 lfsr shall advance every edge as a right-shifting Galois LFSR: next = (lfsr>>1) XOR (lsb ? 16'hB400 : 0).
REQ-024 If lfsr is ever 0, it shall reload LFSR_SEED on the next edge.
REQ-025 parity shall be combinational from the current lfsr; all other outputs shall be registered.
REQ-026 tgl, tgl4, pulse, and lfsr shall run independently of FSM state.

Reset
REQ-027 With rst=1 at an edge: cnt=0, state=IDLE, tgl=0, tgl4=0, pulse=0, divider=0, period counter=0, lfsr=LFSR_SEED, gray=0.
REQ-028 Reset mid-operation shall take precedence over all other updates at that edge.
REQ-029 All registers shall carry declared power-up values equal to their reset values, so the block runs correctly when rst is tied low or left unconnected.

Configuration
REQ-030 Macro SUB_GRAY_EN defined: gray shall be the registered value (cnt>>1) XOR cnt, updated in the same cycle as cnt. Undefined: gray shall be constant 0 and no Gray logic shall be generated.

Verification
REQ-031 Reset held 2 cycles, then released: cnt=0, state=IDLE, and lfsr=16'hACE1 during reset; state=RUN after the first edge post-release.
REQ-032 One edge after release with rst=0: lfsr=16'hE270; parity equals the XOR-reduction of the lfsr value at that time.
REQ-033 RUN from cnt=0 for 255 edges, so cnt=255: the next edge gives cnt=0 and state=PAUSE; after 4 more edges, state=RUN; the edge after that gives cnt=1.
REQ-034 Free run for 64 cycles: pulse is high exactly 4 times, each 16 cycles apart; tgl4 has a period of 8 cycles.
REQ-035 Assert rst while in PAUSE with cnt=0: at the next edge all outputs equal their reset values; with SUB_GRAY_EN defined and cnt=5, gray=7.
REQ-036 Leave rst unconnected: no output is X after the first edge, and cnt reaches 10 after 11 edges.
